// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and a
// single-beat 128-bit line memory interface. All storage is in flops.
module data_cache #(
    parameter int unsigned LINES  = 64,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_re,
    input  logic [3:0]        cpu_we,
    input  logic [31:0]       cpu_din,
    output logic [31:0]       cpu_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [27:0]       mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data
);

    localparam int unsigned INDEX_W = $clog2(LINES);
    localparam int unsigned TAG_W   = 28 - INDEX_W;

    typedef enum logic [2:0] {StIdle, StLookup, StWbReq, StRfReq, StRfWait} state_e;

    state_e state_q, state_d;

    logic [31:2] req_addr_q;
    logic [3:0]  req_we_q;
    logic [31:0] req_din_q;
    logic [31:0] dout_q;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         off;
    logic               is_write;
    logic               hit;
    logic [LINE_W-1:0]  line;
    logic [31:0]        word;
    logic               req_in;

    logic accept, write_hit, rd_done, install, clear_dirty;

    // Byte-address bits [1:0] carry no information for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] din,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = din[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] l,
                                                     input logic [1:0] o,
                                                     input logic [31:0] din,
                                                     input logic [3:0] be);
        logic [LINE_W-1:0] r;
        r = l;
        r[32*int'(o) +: 32] = merge_word(l[32*int'(o) +: 32], din, be);
        return r;
    endfunction

    assign idx      = req_addr_q[4 +: INDEX_W];
    assign req_tag  = req_addr_q[31 -: TAG_W];
    assign off      = req_addr_q[3:2];
    assign is_write = |req_we_q;
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
    assign line     = data_q[idx];
    assign word     = line[32*int'(off) +: 32];
    assign req_in   = cpu_re || (|cpu_we);

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        accept        = 1'b0;
        write_hit     = 1'b0;
        rd_done       = 1'b0;
        install       = 1'b0;
        clear_dirty   = 1'b0;
        unique case (state_q)
            StIdle: begin
                accept = req_in;
                if (accept) state_d = StLookup;
            end
            StLookup: begin
                if (hit) begin
                    rd_done   = !is_write;
                    write_hit = is_write;
                    // A hit frees the pipeline this cycle, so the next request can chain on.
                    accept    = req_in;
                    state_d   = accept ? StLookup : StIdle;
                end else begin
                    stall   = 1'b1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWbReq : StRfReq;
                end
            end
            StWbReq: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {tag_q[idx], idx};
                mem_req_data  = line;
                if (mem_req_ready) begin
                    clear_dirty = 1'b1;
                    state_d     = StRfReq;
                end
            end
            StRfReq: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = req_addr_q[31:4];
                if (mem_req_ready) state_d = StRfWait;
            end
            StRfWait: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    install = 1'b1;
                    state_d = StLookup;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cpu_dout = rd_done ? word : dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            req_we_q   <= '0;
            req_din_q  <= '0;
            dout_q     <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_addr_q <= cpu_addr[31:2];
                req_we_q   <= cpu_we;
                req_din_q  <= cpu_din;
            end
            if (rd_done) dout_q <= word;
            if (write_hit) dirty_q[idx] <= 1'b1;
            if (clear_dirty) dirty_q[idx] <= 1'b0;
            if (install) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= is_write;
            end
        end
    end

    // Tag and data contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (write_hit) data_q[idx] <= merge_line(line, off, req_din_q, req_we_q);
        if (install) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= is_write ? merge_line(mem_resp_data, off, req_din_q, req_we_q)
                                    : mem_resp_data;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: table of hit vectors plus hand-written miss, eviction,
// handshake-stall, address-wrap and reset-during-refill sequences.
module tb_data_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cpu_addr;
    logic         cpu_re;
    logic [3:0]   cpu_we;
    logic [31:0]  cpu_din;
    logic [31:0]  cpu_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_cache #(.LINES(64), .LINE_W(128)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic [3:0]  we;
        logic [31:0] din;
        logic        chk_dout;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic re, input logic [3:0] we,
                         input logic [31:0] din);
        cpu_addr = a;
        cpu_re   = re;
        cpu_we   = we;
        cpu_din  = din;
    endtask

    task automatic drop();
        cpu_re = 1'b0;
        cpu_we = 4'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        drive(v.addr, v.re, v.we, v.din);
        @(negedge clk);
        check("hit_stall", stall, 1'b0);
        check("hit_no_memreq", mem_req_valid, 1'b0);
        if (v.chk_dout) check("hit_dout", cpu_dout, v.exp_dout);
        drop();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_valid_seen", mem_req_valid, 1'b1);
    endtask

    task automatic do_miss(input logic [31:0] a, input logic re, input logic [3:0] we,
                           input logic [31:0] din, input logic exp_wb,
                           input logic [27:0] wb_addr, input logic [127:0] wb_data,
                           input logic [27:0] rf_addr, input logic [127:0] resp,
                           input int ready_delay, input logic chk_dout,
                           input logic [31:0] exp_dout);
        @(negedge clk);
        drive(a, re, we, din);
        @(negedge clk);
        check("miss_lookup_stall", stall, 1'b1);
        if (exp_wb) begin
            wait_req();
            check("wb_rw", mem_req_rw, 1'b1);
            check("wb_addr", mem_req_addr, wb_addr);
            check("wb_data", mem_req_data, wb_data);
            check("wb_stall", stall, 1'b1);
            for (int i = 0; i < ready_delay; i++) begin
                @(negedge clk);
                check("wb_hold_valid", mem_req_valid, 1'b1);
                check("wb_hold_addr", mem_req_addr, wb_addr);
                check("wb_hold_data", mem_req_data, wb_data);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
        end
        wait_req();
        check("rf_rw", mem_req_rw, 1'b0);
        check("rf_addr", mem_req_addr, rf_addr);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rfwait_valid_low", mem_req_valid, 1'b0);
        check("rfwait_stall", stall, 1'b1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("replay_stall", stall, 1'b0);
        if (chk_dout) check("replay_dout", cpu_dout, exp_dout);
        drop();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        // Line at index 0x10 after the first refill: {0x44, 0x33, 0x22, 0x11}, word 0 low.
        vecs[0] = '{32'h0000010C, 1'b1, 4'b0000, 32'h0, 1'b1, 32'h00000044};
        vecs[1] = '{32'h00000100, 1'b1, 4'b0000, 32'h0, 1'b1, 32'h00000011};
        vecs[2] = '{32'h00000104, 1'b0, 4'b0110, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[3] = '{32'h00000104, 1'b1, 4'b0000, 32'h0, 1'b1, 32'h00BBCC22};
        vecs[4] = '{32'h00000108, 1'b0, 4'b1000, 32'h5A000000, 1'b0, 32'h0};
        vecs[5] = '{32'h00000108, 1'b1, 4'b0000, 32'h0, 1'b1, 32'h5A000033};

        reset          = 1'b1;
        cpu_addr       = '0;
        cpu_re         = 1'b0;
        cpu_we         = '0;
        cpu_din        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_memreq", mem_req_valid, 1'b0);
        check("rst_dout", cpu_dout, 32'h0);
        reset = 1'b0;

        // Cold read: offset 1 of the refilled line.
        do_miss(32'h00000104, 1'b1, 4'b0, 32'h0, 1'b0, 28'h0, 128'h0, 28'h0000010,
                128'h00000044_00000033_00000022_00000011, 0, 1'b1, 32'h00000022);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Back-to-back hits, one per cycle.
        @(negedge clk);
        drive(32'h00000100, 1'b1, 4'b0, 32'h0);
        @(negedge clk);
        check("b2b_0_stall", stall, 1'b0);
        check("b2b_0_dout", cpu_dout, 32'h00000011);
        drive(32'h00000108, 1'b1, 4'b0, 32'h0);
        @(negedge clk);
        check("b2b_1_stall", stall, 1'b0);
        check("b2b_1_dout", cpu_dout, 32'h5A000033);
        drop();
        @(negedge clk);
        check("dout_holds", cpu_dout, 32'h5A000033);

        // Conflict miss evicts the dirty line; ready held low 3 cycles.
        do_miss(32'h00000504, 1'b1, 4'b0, 32'h0, 1'b1, 28'h0000010,
                128'h00000044_5A000033_00BBCC22_00000011, 28'h0000050,
                128'h0005040C_00050408_00050404_00050400, 3, 1'b1, 32'h00050404);

        // Write miss with allocate and merge.
        do_miss(32'h00002000, 1'b0, 4'b1111, 32'hDEADBEEF, 1'b0, 28'h0, 128'h0, 28'h0000200,
                128'h00000003_00000002_00000001_00000099, 0, 1'b0, 32'h0);
        apply_vec('{32'h00002000, 1'b1, 4'b0, 32'h0, 1'b1, 32'hDEADBEEF});
        apply_vec('{32'h00002004, 1'b1, 4'b0, 32'h0, 1'b1, 32'h00000001});

        // Eviction of the merged line.
        do_miss(32'h00000000, 1'b1, 4'b0, 32'h0, 1'b1, 28'h0000200,
                128'h00000003_00000002_00000001_DEADBEEF, 28'h0000000,
                128'h000000A3_000000A2_000000A1_000000A0, 1, 1'b1, 32'h000000A0);

        // Highest index and top of address space.
        do_miss(32'hFFFFFFFC, 1'b1, 4'b0, 32'h0, 1'b0, 28'h0, 128'h0, 28'hFFFFFFF,
                128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 0, 1'b1, 32'hCAFE0003);
        apply_vec('{32'hFFFFFFF0, 1'b1, 4'b0, 32'h0, 1'b1, 32'hCAFE0000});

        // Reset while waiting for refill data.
        @(negedge clk);
        drive(32'h00003000, 1'b1, 4'b0, 32'h0);
        @(negedge clk);
        check("rst_seq_miss", stall, 1'b1);
        wait_req();
        check("rst_seq_rf_addr", mem_req_addr, 28'h0000300);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rst_seq_in_rfwait", stall, 1'b1);
        reset = 1'b1;
        #1;
        check("midmiss_rst_stall", stall, 1'b0);
        check("midmiss_rst_memreq", mem_req_valid, 1'b0);
        check("midmiss_rst_dout", cpu_dout, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drop();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h11111111_22222222_33333333_44444444;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("stray_resp_stall", stall, 1'b0);
        check("stray_resp_memreq", mem_req_valid, 1'b0);
        // Everything was invalidated, so the same address misses cleanly again.
        do_miss(32'h00003000, 1'b1, 4'b0, 32'h0, 1'b0, 28'h0, 128'h0, 28'h0000300,
                128'h0000000D_0000000C_0000000B_0000000A, 0, 1'b1, 32'h0000000A);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
